axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 26 ++
 rtl/rd_arb_prio_pick.sv | 48 ++++
 rtl/axi_rd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_pkg
// Shared definitions for the read-port arbiter slice:
//   arb_state_e     - arbiter FSM states (IDLE, BUSY, GAP)
//   NUM_REQ_DEF     - default number of read requesters
//   LEN_CACHE_LINE  - burst length-minus-one of a cache-line fill (8 beats)
//   LEN_SINGLE_BEAT - burst length-minus-one of a single-beat read
//   idx_width()     - width of a requester index (never less than 1 bit)
// -----------------------------------------------------------------------------
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int         NUM_REQ_DEF     = 4;
  localparam logic [7:0] LEN_CACHE_LINE  = 8'h7;
  localparam logic [7:0] LEN_SINGLE_BEAT = 8'h0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_arb_prio_pick.sv
// -----------------------------------------------------------------------------
// rd_arb_prio_pick
// Combinational winner selection. Requesters that are both requesting and
// aged form the candidate set when it is non-empty; otherwise every requester
// is a candidate. The lowest index among the candidates wins.
// Ports:
//   req_vec  [N]  - active requests
//   aged_vec [N]  - requesters that reached the age limit
//   pick_oh  [N]  - one-hot winner (all zero when nothing requests)
//   pick_idx [IW] - binary index of the winner (0 when nothing requests)
// -----------------------------------------------------------------------------
module rd_arb_prio_pick
  import axi_rd_arbiter_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_vec,
  input  logic [N-1:0]  aged_vec,
  output logic [N-1:0]  pick_oh,
  output logic [IW-1:0] pick_idx
);

  logic [N-1:0] cand_s;
  logic         found_s;

  // Lowest-index scan over the candidate set
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    found_s  = 1'b0;
    if (|(req_vec & aged_vec)) begin
      cand_s = req_vec & aged_vec;
    end else begin
      cand_s = req_vec;
    end
    for (int i = 0; i < N; i++) begin
      if (cand_s[i] && !found_s) begin
        pick_oh[i] = 1'b1;
        pick_idx   = IW'(i);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Arbitrates NUM_REQ read requesters onto one shared bridge read port.
// A burst is granted in IDLE, runs in BUSY until its last beat, then one GAP
// cycle follows so a requester dropping req_i after done_o is not re-granted.
// Optional build macro ARB_AGING_EN: requesters that lose AGE_LIMIT
// consecutive arbitrations while requesting are promoted over fixed priority.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req_i/addr_i/len_i - per-requester request, start address, length-1
//   rdata_o            - bridge read data broadcast to all requesters
//   rvalid_o/done_o    - per-requester beat valid / last-beat pulse
//   ren_o/raddr_o/rlen_o - registered request to the bridge
//   rdata_i/rdata_valid_i - bridge read data and beat valid
//   spurious_o         - sticky: bridge beat seen outside BUSY
// -----------------------------------------------------------------------------
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int AGE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0][31:0] addr_i,
  input  logic [NUM_REQ-1:0][7:0] len_i,
  output logic [31:0]             rdata_o,
  output logic [NUM_REQ-1:0]      rvalid_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic                    ren_o,
  output logic [31:0]             raddr_o,
  output logic [7:0]              rlen_o,
  input  logic [31:0]             rdata_i,
  input  logic                    rdata_valid_i,
  output logic                    spurious_o
);

  localparam int IW = idx_width(NUM_REQ);

  if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_bad_age_limit
    $error("axi_rd_arbiter: AGE_LIMIT must be within 1..15");
  end

  arb_state_e          state_r, state_s;
  logic [NUM_REQ-1:0]  grant_oh_r;
  logic [7:0]          beat_cnt_r;
  logic [NUM_REQ-1:0]  win_oh_s, aged_s;
  logic [IW-1:0]       win_idx_s;
  logic                arb_s, busy_s, last_beat_s;

  assign arb_s       = (state_r == ST_IDLE) && (|req_i);
  assign busy_s      = (state_r == ST_BUSY);
  assign last_beat_s = busy_s && rdata_valid_i && (beat_cnt_r == rlen_o);

  rd_arb_prio_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_vec  (req_i),
    .aged_vec (aged_s),
    .pick_oh  (win_oh_s),
    .pick_idx (win_idx_s)
  );

`ifdef ARB_AGING_EN
  localparam logic [3:0] AGE_LIM_C = 4'(AGE_LIMIT);
  logic [NUM_REQ-1:0][3:0] age_r;

  // Saturating loss counters: count lost decisions, clear on win or idle request
  always_ff @(posedge clk) begin
    if (rst) begin
      age_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_i[i]) begin
          age_r[i] <= 4'd0;
        end else if (arb_s && win_oh_s[i]) begin
          age_r[i] <= 4'd0;
        end else if (arb_s && (age_r[i] != 4'hF)) begin
          age_r[i] <= age_r[i] + 4'd1;
        end else begin
          age_r[i] <= age_r[i];
        end
      end
    end
  end

  // Promotion flags for requesters that reached the age limit
  always_comb begin
    aged_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (age_r[i] >= AGE_LIM_C) begin
        aged_s[i] = 1'b1;
      end else begin
        aged_s[i] = 1'b0;
      end
    end
  end
`else
  assign aged_s = '0;
`endif

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_i) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_beat_s) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_GAP:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, grant, bridge request and beat counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      grant_oh_r <= '0;
      ren_o      <= 1'b0;
      raddr_o    <= 32'd0;
      rlen_o     <= 8'd0;
      beat_cnt_r <= 8'd0;
    end else begin
      state_r <= state_s;
      if (arb_s) begin
        grant_oh_r <= win_oh_s;
        ren_o      <= 1'b1;
        raddr_o    <= addr_i[win_idx_s];
        rlen_o     <= len_i[win_idx_s];
        beat_cnt_r <= 8'd0;
      end else if (last_beat_s) begin
        // raddr_o/rlen_o keep the finished burst; only the grant is dropped
        grant_oh_r <= '0;
        ren_o      <= 1'b0;
        beat_cnt_r <= 8'd0;
      end else if (busy_s && rdata_valid_i) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  // Sticky flag for bridge beats arriving with no burst outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      spurious_o <= 1'b0;
    end else if (rdata_valid_i && !busy_s) begin
      spurious_o <= 1'b1;
    end else begin
      spurious_o <= spurious_o;
    end
  end

  // Beat routing is combinational so requesters see data with zero latency
  assign rdata_o  = rdata_i;
  assign rvalid_o = (busy_s && rdata_valid_i) ? grant_oh_r : '0;
  assign done_o   = last_beat_s ? rvalid_o : '0;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int N = 4;
`ifdef ARB_AGING_EN
  localparam int AGE_LIM = 2;
`else
  localparam int AGE_LIM = 8;
`endif

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_i;
  logic [N-1:0][31:0] addr_i;
  logic [N-1:0][7:0] len_i;
  logic [31:0]       rdata_o;
  logic [N-1:0]      rvalid_o;
  logic [N-1:0]      done_o;
  logic              ren_o;
  logic [31:0]       raddr_o;
  logic [7:0]        rlen_o;
  logic [31:0]       rdata_i;
  logic              rdata_valid_i;
  logic              spurious_o;

  axi_rd_arbiter #(.NUM_REQ(N), .AGE_LIMIT(AGE_LIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .len_i         (len_i),
    .rdata_o       (rdata_o),
    .rvalid_o      (rvalid_o),
    .done_o        (done_o),
    .ren_o         (ren_o),
    .raddr_o       (raddr_o),
    .rlen_o        (rlen_o),
    .rdata_i       (rdata_i),
    .rdata_valid_i (rdata_valid_i),
    .spurious_o    (spurious_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 = waiting for a request, 1 = burst outstanding, 2 = turnaround
  int           m_phase = 0;
  int           m_win   = 0;
  logic [31:0]  m_addr  = '0;
  logic [7:0]   m_len   = '0;
  int           m_left  = 0;   // beats still to come in the current burst
  bit           m_spur  = 1'b0;
  int           m_age [N];
  bit           m_init  = 1'b0;
  logic [N-1:0] m_done_last = '0;

  function automatic logic [N-1:0] exp_rvalid();
    logic [N-1:0] one;
    one = 4'b0001;
    if (m_phase == 1 && rdata_valid_i) return one << m_win;
    else return '0;
  endfunction

  function automatic logic [N-1:0] exp_done();
    if (m_phase == 1 && rdata_valid_i && m_left == 1) return exp_rvalid();
    else return '0;
  endfunction

  task automatic model_step();
    m_done_last = exp_done();
    if (rst) begin
      m_phase = 0; m_win = 0; m_addr = '0; m_len = '0; m_left = 0; m_spur = 1'b0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      m_init = 1'b1;
    end else begin
      if (rdata_valid_i && m_phase != 1) m_spur = 1'b1;
      if (m_phase == 0 && req_i != '0) begin
        int w;
        w = -1;
`ifdef ARB_AGING_EN
        for (int i = 0; i < N; i++)
          if (w < 0 && req_i[i] && m_age[i] >= AGE_LIM) w = i;
`endif
        for (int i = 0; i < N; i++)
          if (w < 0 && req_i[i]) w = i;
        for (int i = 0; i < N; i++) begin
          if (req_i[i] && i != w) m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
          else m_age[i] = 0;
        end
        m_win = w; m_addr = addr_i[w]; m_len = len_i[w];
        m_left = int'(len_i[w]) + 1; m_phase = 1;
      end else begin
        for (int i = 0; i < N; i++) if (!req_i[i]) m_age[i] = 0;
        if (m_phase == 1) begin
          if (rdata_valid_i) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 2;
          end
        end else begin
          m_phase = 0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_age[i] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("cyc_ren", 32'(ren_o), 32'(m_phase == 1));
        if (m_phase == 1) begin
          chk("cyc_raddr", raddr_o, m_addr);
          chk("cyc_rlen", 32'(rlen_o), 32'(m_len));
        end
        chk("cyc_rvalid", 32'(rvalid_o), 32'(exp_rvalid()));
        chk("cyc_done", 32'(done_o), 32'(exp_done()));
        chk("cyc_rdata", rdata_o, rdata_i);
        chk("cyc_spurious", 32'(spurious_o), 32'(m_spur));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0; rdata_valid_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait for a grant, then play the bridge with a beat every cycle
  task automatic run_burst(output logic [N-1:0] who, output int beats, output logic [31:0] a);
    int  t;
    bit  fin;
    who = '0; beats = 0; a = '0; t = 0; fin = 1'b0;
    while (ren_o !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("burst_grant_seen", 32'(ren_o), 32'd1);
    a = raddr_o;
    t = 0;
    while (!fin && t < 300) begin
      rdata_valid_i = 1'b1;
      rdata_i = $urandom;
      #1;
      if (rvalid_o != '0) beats++;
      if (done_o != '0) begin
        who = done_o;
        fin = 1'b1;
      end else begin
        t++;
      end
      tick();
    end
    rdata_valid_i = 1'b0;
  endtask

  logic [N-1:0] who;
  int           beats;
  logic [31:0]  a;

  initial begin
    rst = 1'b1; req_i = '0; addr_i = '0; len_i = '0;
    rdata_i = '0; rdata_valid_i = 1'b0;
    repeat (3) tick();
    // reset state
    chk("rst_ren", 32'(ren_o), 32'd0);
    chk("rst_raddr", raddr_o, 32'd0);
    chk("rst_rlen", 32'(rlen_o), 32'd0);
    chk("rst_spurious", 32'(spurious_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst = 1'b0;
    tick();

    // single-beat read by requester 2
    req_i = 4'b0100; addr_i[2] = 32'h1FC0_0004; len_i[2] = LEN_SINGLE_BEAT;
    tick();
    #1;
    chk("single_ren", 32'(ren_o), 32'd1);
    chk("single_raddr", raddr_o, 32'h1FC0_0004);
    chk("single_rlen", 32'(rlen_o), 32'd0);
    rdata_valid_i = 1'b1; rdata_i = 32'hA5A5_0001;
    #1;
    chk("single_rvalid", 32'(rvalid_o), 32'h4);
    chk("single_done", 32'(done_o), 32'h4);
    tick();
    rdata_valid_i = 1'b0; req_i = '0;
    #1;
    chk("single_ren_low", 32'(ren_o), 32'd0);
    tick(); tick();

    // two cache-line requesters: 0 first, then 1
    addr_i[0] = 32'h0000_1000; addr_i[1] = 32'h0000_2000;
    len_i[0] = LEN_CACHE_LINE; len_i[1] = LEN_CACHE_LINE;
    req_i = 4'b0011;
    tick();
    run_burst(who, beats, a);
    chk("pair_first_who", 32'(who), 32'h1);
    chk("pair_first_beats", 32'(beats), 32'd8);
    chk("pair_first_addr", a, 32'h0000_1000);
    req_i[0] = 1'b0;
    run_burst(who, beats, a);
    chk("pair_second_who", 32'(who), 32'h2);
    chk("pair_second_beats", 32'(beats), 32'd8);
    chk("pair_second_addr", a, 32'h0000_2000);
    req_i[1] = 1'b0;
    tick(); tick();

    // reset after beat 3 of an 8-beat burst
    req_i = 4'b0010; addr_i[1] = 32'h0000_3000; len_i[1] = LEN_CACHE_LINE;
    tick();
    repeat (3) begin
      rdata_valid_i = 1'b1; rdata_i = $urandom;
      tick();
    end
    rst = 1'b1; req_i = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_ren", 32'(ren_o), 32'd0);
    repeat (4) begin
      rdata_i = $urandom;
      #1;
      chk("rstmid_rvalid", 32'(rvalid_o), 32'd0);
      chk("rstmid_done", 32'(done_o), 32'd0);
      tick();
    end
    rdata_valid_i = 1'b0;
    #1;
    chk("rstmid_spurious", 32'(spurious_o), 32'd1);

    // stray beat while idle
    do_reset();
    tick();
    chk("stray_pre_spurious", 32'(spurious_o), 32'd0);
    rdata_valid_i = 1'b1;
    #1;
    chk("stray_rvalid", 32'(rvalid_o), 32'd0);
    chk("stray_done", 32'(done_o), 32'd0);
    tick();
    rdata_valid_i = 1'b0;
    chk("stray_spurious", 32'(spurious_o), 32'd1);
    repeat (5) tick();
    chk("stray_sticky", 32'(spurious_o), 32'd1);
    do_reset();
    tick();
    chk("stray_cleared", 32'(spurious_o), 32'd0);

    // requesters 0 and 3 always requesting
    addr_i[0] = 32'h0000_0100; addr_i[3] = 32'h0000_0400;
    len_i[0] = LEN_SINGLE_BEAT; len_i[3] = LEN_SINGLE_BEAT;
    req_i = 4'b1001;
    tick();
    run_burst(who, beats, a);
    chk("age_arb1", 32'(who), 32'h1);
    run_burst(who, beats, a);
    chk("age_arb2", 32'(who), 32'h1);
    run_burst(who, beats, a);
`ifdef ARB_AGING_EN
    chk("age_arb3", 32'(who), 32'h8);
    chk("age_arb3_addr", a, 32'h0000_0400);
`else
    chk("age_arb3", 32'(who), 32'h1);
    chk("age_arb3_addr", a, 32'h0000_0100);
`endif
    req_i = '0;
    tick(); tick();
    do_reset();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_done_last[i]) begin
          req_i[i] = 1'b0;
        end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
          req_i[i]  = 1'b1;
          addr_i[i] = $urandom & 32'hFFFF_FFFC;
          case ($urandom_range(0, 2))
            0:       len_i[i] = LEN_SINGLE_BEAT;
            1:       len_i[i] = LEN_CACHE_LINE;
            default: len_i[i] = 8'($urandom_range(0, 15));
          endcase
        end
      end
      if (m_phase == 1 && $urandom_range(0, 63) == 0) req_i[m_win] = 1'b0;
      if (m_phase == 1) rdata_valid_i = ($urandom_range(0, 9) < 6);
      else rdata_valid_i = ($urandom_range(0, 99) == 0);
      rdata_i = $urandom;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; rdata_valid_i = 1'b0; req_i = '0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
